// File: rtl/pispo_pkg.sv
// Shared definitions for the framed parallel/serial converter:
// FSM state encoding and bit-order selectors.
package pispo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic ORDER_MSB = 1'b0;
    localparam logic ORDER_LSB = 1'b1;

endpackage

// File: rtl/pispo_shreg.sv
// Direction-selectable shift register shared by the transmit and capture paths.
// A load takes priority over a shift.
module pispo_shreg
    import pispo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             lsb_first,
    input  logic             bit_in,
    output logic [WIDTH-1:0] shreg,
    output logic             sout_bit
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_en) begin
            shreg_d = load_data;
        end else if (shift_en) begin
            if (lsb_first == ORDER_LSB) begin
                shreg_d = {bit_in, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], bit_in};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign shreg    = shreg_q;
    assign sout_bit = (lsb_first == ORDER_LSB) ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/pispo_frame.sv
// Framed full-duplex parallel/serial converter: FSM, bit counter, frame
// config registers and the captured-word register around pispo_shreg.
module pispo_frame
    import pispo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             lsb_first,
    input  logic             loopback,
    input  logic             sin,
    output logic             sout,
    output logic             sout_valid,
    output logic [WIDTH-1:0] cap_data,
    output logic             cap_valid,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lsb_q, lsb_d;
    logic               loop_q, loop_d;
    logic [WIDTH-1:0]   cap_data_q, cap_data_d;

    logic               load_acc;
    logic               shifting;
    logic               last_bit;
    logic               bit_in;
    logic               sout_bit;
    logic [WIDTH-1:0]   shreg;

    assign load_acc = load_valid && load_ready;
    assign shifting = (state_q == ST_SHIFT);
    assign last_bit = shifting && (cnt_q == CNT_W'(WIDTH-1));
    assign bit_in   = loop_q ? sout_bit : sin;

    pispo_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk       (clk),
        .rst_p     (rst_p),
        .load_en   (load_acc),
        .load_data (load_data),
        .shift_en  (shifting),
        .lsb_first (lsb_q),
        .bit_in    (bit_in),
        .shreg     (shreg),
        .sout_bit  (sout_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load_acc) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = load_acc ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b0;
        sout_valid = 1'b0;
        cap_valid  = 1'b0;
        case (state_q)
            ST_IDLE:  load_ready = 1'b1;
            ST_SHIFT: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
            end
            ST_DONE: begin
                load_ready = 1'b1;
                cap_valid  = 1'b1;
            end
            default: load_ready = 1'b0;
        endcase
    end

    assign sout     = shifting & sout_bit;
    assign cap_data = cap_data_q;

    // The captured word is the shift register after the final shift, so it is
    // formed here from the current contents plus the last incoming bit.
    always_comb begin
        cnt_d      = cnt_q;
        lsb_d      = lsb_q;
        loop_d     = loop_q;
        cap_data_d = cap_data_q;
        if (load_acc) begin
            cnt_d  = '0;
            lsb_d  = lsb_first;
            loop_d = loopback;
        end else if (shifting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (last_bit) begin
            if (lsb_q == ORDER_LSB) begin
                cap_data_d = {bit_in, shreg[WIDTH-1:1]};
            end else begin
                cap_data_d = {shreg[WIDTH-2:0], bit_in};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            cnt_q      <= '0;
            lsb_q      <= 1'b0;
            loop_q     <= 1'b0;
            cap_data_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            lsb_q      <= lsb_d;
            loop_q     <= loop_d;
            cap_data_q <= cap_data_d;
        end
    end

endmodule
